// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller slice.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } vend_state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_3    = 2'b11;

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin-code to credit-value map; code 00 is worth nothing.
module vend_coin_decode
  import vend_pkg::*;
#(
  parameter int CREDIT_W  = 6,
  parameter int COIN1_VAL = 5,
  parameter int COIN2_VAL = 10,
  parameter int COIN3_VAL = 20
) (
  input  logic [1:0]          coin,
  output logic [CREDIT_W-1:0] val
);

  // Select the configured value for the presented coin code.
  always_comb begin
    val = '0;
    case (coin)
      COIN_1:  val = CREDIT_W'(COIN1_VAL);
      COIN_2:  val = CREDIT_W'(COIN2_VAL);
      COIN_3:  val = CREDIT_W'(COIN3_VAL);
      default: val = '0;
    endcase
  end

endmodule

// File: rtl/vend_ctrl_param.sv
// Parametrised vending controller: credit accumulator, vend pulse and
// change/refund port. Change and refund exist only when VEND_CHANGE_EN is
// defined; otherwise overpayment is forfeited and cancel is ignored.
//
// Change port handshake: chg_valid rises with chg_amt and both hold steady
// until a rising edge where chg_valid && chg_ready; that edge completes the
// transfer and chg_valid drops on the following cycle.
module vend_ctrl_param
  import vend_pkg::*;
#(
  parameter int PRICE     = 15,
  parameter int CREDIT_W  = 6,
  parameter int COIN1_VAL = 5,
  parameter int COIN2_VAL = 10,
  parameter int COIN3_VAL = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                chg_ready,
  output logic                vend,
  output logic                coin_rej,
  output logic                chg_valid,
  output logic [CREDIT_W-1:0] chg_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output vend_state_e         state_dbg
);

  localparam logic [CREDIT_W:0]   PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

`ifdef VEND_CHANGE_EN
  localparam bit CHG_EN = 1'b1;
  logic cancel_i;
  logic chg_ready_i;
  assign cancel_i    = cancel;
  assign chg_ready_i = chg_ready;
`else
  localparam bit CHG_EN = 1'b0;
  logic cancel_i;
  logic chg_ready_i;
  logic unused_chg_inputs;
  assign cancel_i          = 1'b0;
  assign chg_ready_i       = 1'b0;
  assign unused_chg_inputs = cancel ^ chg_ready;
`endif

  vend_state_e         state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
  logic                vend_q, vend_d;
  logic                coin_rej_q, coin_rej_d;
  logic                chg_valid_q, chg_valid_d;
  logic                busy_q, busy_d;

  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic                coin_present;
  logic [CREDIT_W-1:0] excess;

  vend_coin_decode #(
    .CREDIT_W (CREDIT_W),
    .COIN1_VAL(COIN1_VAL),
    .COIN2_VAL(COIN2_VAL),
    .COIN3_VAL(COIN3_VAL)
  ) u_decode (
    .coin(coin),
    .val (coin_val)
  );

  // One extra bit on the sum exposes accumulator overflow.
  assign sum          = {1'b0, credit_q} + {1'b0, coin_val};
  assign coin_present = (coin != COIN_NONE);
  assign excess       = credit_q - PRICE_C;

  // Next-state, accumulator and registered-output computation.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    chg_amt_d  = chg_amt_q;
    coin_rej_d = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if ((state_q == COLLECT) && cancel_i) begin
          // Refund wins over a simultaneous coin, which goes back.
          state_d    = CHANGE;
          chg_amt_d  = credit_q;
          coin_rej_d = coin_present;
        end else if (coin_present) begin
          if (sum[CREDIT_W]) begin
            coin_rej_d = 1'b1;
          end else begin
            credit_d = sum[CREDIT_W-1:0];
            state_d  = (sum >= PRICE_X) ? VEND : COLLECT;
          end
        end
      end
      VEND: begin
        coin_rej_d = coin_present;
        if (CHG_EN && (excess != '0)) begin
          state_d   = CHANGE;
          chg_amt_d = excess;
        end else begin
          state_d  = IDLE;
          credit_d = '0;
        end
      end
      CHANGE: begin
        coin_rej_d = coin_present;
        if (chg_valid_q && chg_ready_i) begin
          state_d   = IDLE;
          credit_d  = '0;
          chg_amt_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
    vend_d      = (state_d == VEND);
    chg_valid_d = (state_d == CHANGE);
    busy_d      = (state_d == VEND) || (state_d == CHANGE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      chg_amt_q   <= '0;
      vend_q      <= 1'b0;
      coin_rej_q  <= 1'b0;
      chg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      chg_amt_q   <= chg_amt_d;
      vend_q      <= vend_d;
      coin_rej_q  <= coin_rej_d;
      chg_valid_q <= chg_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign vend      = vend_q;
  assign coin_rej  = coin_rej_q;
  assign chg_valid = chg_valid_q;
  assign chg_amt   = chg_amt_q;
  assign credit    = credit_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_vend_ctrl_param.sv
// Directed bench for vend_ctrl_param: default-parameter instance plus a
// CREDIT_W=4 instance for overflow. Expectations follow VEND_CHANGE_EN.
module tb_vend_ctrl_param;
  import vend_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       chg_ready = 1'b0;
  logic       vend, coin_rej, chg_valid, busy;
  logic [5:0] chg_amt, credit;
  vend_state_e state_dbg;

  logic [1:0] coin4 = 2'b00;
  logic       cancel4 = 1'b0;
  logic       chg_ready4 = 1'b0;
  logic       vend4, coin_rej4, chg_valid4, busy4;
  logic [3:0] chg_amt4, credit4;
  vend_state_e state_dbg4;

  int n_assert = 0;
  int n_fail   = 0;

  // Clock and DUTs.
  always #5 clk = ~clk;

  vend_ctrl_param dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .chg_ready(chg_ready),
    .vend(vend), .coin_rej(coin_rej), .chg_valid(chg_valid), .chg_amt(chg_amt),
    .credit(credit), .busy(busy), .state_dbg(state_dbg)
  );

  vend_ctrl_param #(.PRICE(15), .CREDIT_W(4)) dut4 (
    .clk(clk), .rst(rst), .coin(coin4), .cancel(cancel4), .chg_ready(chg_ready4),
    .vend(vend4), .coin_rej(coin_rej4), .chg_valid(chg_valid4), .chg_amt(chg_amt4),
    .credit(credit4), .busy(busy4), .state_dbg(state_dbg4)
  );

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check every output of the default instance.
  task automatic chk_all(input string tag, input vend_state_e st, input int cr,
                         input bit v, input bit rej, input bit cv, input int ca);
    chk({tag, ".state"},     32'(state_dbg), 32'(st));
    chk({tag, ".credit"},    32'(credit),    32'(cr));
    chk({tag, ".vend"},      32'(vend),      32'(v));
    chk({tag, ".coin_rej"},  32'(coin_rej),  32'(rej));
    chk({tag, ".chg_valid"}, 32'(chg_valid), 32'(cv));
    chk({tag, ".chg_amt"},   32'(chg_amt),   32'(ca));
    chk({tag, ".busy"},      32'(busy),      32'((st == VEND) || (st == CHANGE)));
  endtask

  // Directed sequence.
  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_all("reset", IDLE, 0, 0, 0, 0, 0);

    // Cancel in IDLE does nothing.
    cancel = 1'b1; step(); cancel = 1'b0;
    chk_all("idle_cancel", IDLE, 0, 0, 0, 0, 0);

    // 5 + 10: exact price.
    coin = COIN_1; step();
    chk_all("exact_c1", COLLECT, 5, 0, 0, 0, 0);
    coin = COIN_2; step();
    chk_all("exact_vend", VEND, 15, 1, 0, 0, 0);
    coin = COIN_NONE; step();
    chk_all("exact_idle", IDLE, 0, 0, 0, 0, 0);

    // 10 + 10: 5 change, dispenser stalls 3 cycles.
    coin = COIN_2; step();
    chk_all("chg_c1", COLLECT, 10, 0, 0, 0, 0);
    step();
    chk_all("chg_vend", VEND, 20, 1, 0, 0, 0);
    coin = COIN_NONE; step();
`ifdef VEND_CHANGE_EN
    chk_all("chg_wait0", CHANGE, 20, 0, 0, 1, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_all("chg_stall", CHANGE, 20, 0, 0, 1, 5);
    end
    chg_ready = 1'b1; step(); chg_ready = 1'b0;
    chk_all("chg_done", IDLE, 0, 0, 0, 0, 0);
`else
    chk_all("forfeit_idle", IDLE, 0, 0, 0, 0, 0);
`endif

    // Coin 5, then cancel together with coin 10.
    coin = COIN_1; step();
    chk_all("cancel_c1", COLLECT, 5, 0, 0, 0, 0);
    coin = COIN_2; cancel = 1'b1; step(); cancel = 1'b0; coin = COIN_NONE;
`ifdef VEND_CHANGE_EN
    chk_all("cancel_refund", CHANGE, 5, 0, 1, 1, 5);
    chg_ready = 1'b1; step(); chg_ready = 1'b0;
    chk_all("cancel_done", IDLE, 0, 0, 0, 0, 0);
`else
    chk_all("cancel_ignored", VEND, 15, 1, 0, 0, 0);
    step();
    chk_all("cancel_ign_idle", IDLE, 0, 0, 0, 0, 0);
`endif

    // Coin 20, then coins presented during VEND and CHANGE.
    coin = COIN_3; step();
    chk_all("c20_vend", VEND, 20, 1, 0, 0, 0);
    coin = COIN_1; step();
`ifdef VEND_CHANGE_EN
    chk_all("c20_rej_vend", CHANGE, 20, 0, 1, 1, 5);
    step();
    chk_all("c20_rej_chg", CHANGE, 20, 0, 1, 1, 5);
    coin = COIN_NONE; chg_ready = 1'b1; step(); chg_ready = 1'b0;
    chk_all("c20_done", IDLE, 0, 0, 0, 0, 0);
`else
    chk_all("c20_rej_vend", IDLE, 0, 0, 1, 0, 0);
    coin = COIN_NONE; step();
    chk_all("c20_idle", IDLE, 0, 0, 0, 0, 0);
`endif

    // Coin right after completion is accepted; 25 total owes 10.
    coin = COIN_1; step();
    chk_all("post_c1", COLLECT, 5, 0, 0, 0, 0);
    coin = COIN_3; step();
    chk_all("c25_vend", VEND, 25, 1, 0, 0, 0);
    coin = COIN_NONE; step();
`ifdef VEND_CHANGE_EN
    chk_all("c25_chg", CHANGE, 25, 0, 0, 1, 10);
`else
    chk_all("c25_idle", IDLE, 0, 0, 0, 0, 0);
`endif
    // Reset while change is pending discards it.
    rst = 1'b1; step(); rst = 1'b0;
    chk_all("rst_mid", IDLE, 0, 0, 0, 0, 0);

    // Narrow accumulator: 10 + 10 overflows 4 bits.
    coin4 = COIN_2; step();
    chk("w4_c1.credit", 32'(credit4), 10);
    chk("w4_c1.rej", 32'(coin_rej4), 0);
    step();
    chk("w4_ovf.rej", 32'(coin_rej4), 1);
    chk("w4_ovf.credit", 32'(credit4), 10);
    chk("w4_ovf.state", 32'(state_dbg4), 32'(COLLECT));
    coin4 = COIN_1; step();
    chk("w4_vend.vend", 32'(vend4), 1);
    chk("w4_vend.credit", 32'(credit4), 15);
    chk("w4_vend.rej", 32'(coin_rej4), 0);
    coin4 = COIN_NONE; step();
    chk("w4_end.state", 32'(state_dbg4), 32'(IDLE));
    chk("w4_end.chg_valid", 32'(chg_valid4), 0);
    chk("w4_end.credit", 32'(credit4), 0);
    chk("w4_end.vend", 32'(vend4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
